// File: rtl/unary_stream_collector.sv
// unary_stream_collector
// Collects a serial unary bit stream (bit + valid) into frames of INPUT_WIDTH
// accepted bits. It returns the number of ones in each frame through a
// valid/ready handshake. While a frame is still arriving, it exposes running
// lower and upper bounds of the final count.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no partial frame, no pending result
// COLLECT | frame in progress, 1..INPUT_WIDTH-1 bits accepted
// HOLD    | result presented, waiting for result_ready; counters are zero
module unary_stream_collector #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_bit,
    input  logic                   in_valid,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] ones_count,
    output logic [COUNT_WIDTH-1:0] bit_count,
    output logic [COUNT_WIDTH-1:0] lower_bound,
    output logic [COUNT_WIDTH-1:0] upper_bound,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   drop_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] FULL     = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(INPUT_WIDTH - 1);

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   ones_d, bits_d, result_d;
    logic                     result_valid_d, drop_err_d;
    logic                     accept, last_bit, handshake, drop;
    logic [COUNT_WIDTH-1:0]   bit_ext;

    // Acceptance and handshake qualifiers. A HOLD bit is taken only when the
    // handshake completes on the same edge. The counters are zero in HOLD, so
    // the bit simply starts the next frame.
    always_comb begin
        bit_ext   = COUNT_WIDTH'(in_bit);
        handshake = (state_q == HOLD) && result_ready;
        accept    = in_valid && ((state_q != HOLD) || result_ready);
        drop      = in_valid && (state_q == HOLD) && !result_ready;
        last_bit  = accept && (bit_count == LAST_IDX);
    end

    // Next-state, counter, result and error update.
    always_comb begin
        state_d        = state_q;
        ones_d         = ones_count;
        bits_d         = bit_count;
        result_d       = result;
        result_valid_d = result_valid;
        drop_err_d     = drop_err | drop;

        if (handshake) begin
            result_valid_d = 1'b0;
            state_d        = IDLE;
        end

        if (accept) begin
            if (last_bit) begin
                result_d       = ones_count + bit_ext;
                result_valid_d = 1'b1;
                ones_d         = '0;
                bits_d         = '0;
                state_d        = HOLD;
            end else begin
                ones_d         = ones_count + bit_ext;
                bits_d         = bit_count + COUNT_WIDTH'(1);
                state_d        = COLLECT;
            end
        end
    end

    // State and datapath registers; the reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ones_count   <= '0;
            bit_count    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_count   <= ones_d;
            bit_count    <= bits_d;
            result       <= result_d;
            result_valid <= result_valid_d;
            drop_err     <= drop_err_d;
        end
    end

    // Bounds come straight from the registers. Outside COLLECT the counters
    // are zero, so the bounds read 0 / INPUT_WIDTH.
    always_comb begin
        lower_bound = ones_count;
        upper_bound = ones_count + FULL - bit_count;
        busy        = (state_q != IDLE);
    end

endmodule
